pal_mode_detect: RTL and testbench

Input-side video mode detector that sits directly upstream of the PAL-to-720p DDR stage. It synchronizes the raw PAL/VGA hsync and vsync into the `clk` domain and measures lines per frame and clocks per frame. It classifies the source as 50 Hz, 60 Hz and/or VGA passthrough, with multi-frame stability hysteresis and loss-of-signal timeout. Its registered mode flags drive the 50/60 Hz generator select and passthrough select, replacing ad-hoc per-cycle decisions.

---
 rtl/pal_mode_detect.sv | 193 +++++++++++++++++++
 tb/tb_pal_mode_detect.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pal_mode_detect.sv
// PAL/VGA input mode detector: syncs hsync/vsync, measures lines and clocks per frame,
// classifies 50 Hz / 60 Hz / VGA with stability hysteresis. Optional PAL_MODE_DETECT_GLITCH_FILTER_EN.
module pal_mode_detect #(
  parameter int CLK_HZ        = 74_250_000,
  parameter int PASS_LINES    = 400,
  parameter int STABLE_FRAMES = 3,
  parameter int TIMEOUT_CLKS  = CLK_HZ / 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pal_hsync,
  input  logic        i_pal_vsync,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_hsync_rise,
  output logic        o_vsync_rise,
  output logic [10:0] o_lines,
  output logic [23:0] o_frame_clks,
  output logic        o_valid,
  output logic        o_50hz,
  output logic        o_60hz,
  output logic        o_passthrough
);

  localparam logic [23:0] P50_MIN = 24'(CLK_HZ / 55);
  localparam logic [23:0] TO_CLKS = 24'(TIMEOUT_CLKS);
  localparam logic [10:0] PASS_L  = 11'(PASS_LINES);
  localparam logic [3:0]  STAB    = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  logic [2:0] hs, vs;
  logic       h_lvl, v_lvl, h_rise, v_rise;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hs <= '0;
      vs <= '0;
    end else begin
      hs <= {hs[1:0], i_pal_hsync};
      vs <= {vs[1:0], i_pal_vsync};
    end
  end

`ifdef PAL_MODE_DETECT_GLITCH_FILTER_EN
  // A new level is taken only once s[1] has disagreed with the accepted level for 3 clocks.
  logic       h_acc, v_acc, h_take, v_take;
  logic [1:0] h_cnt, v_cnt;

  assign h_take = (hs[1] != h_acc) && (h_cnt == 2'd2);
  assign v_take = (vs[1] != v_acc) && (v_cnt == 2'd2);
  assign h_lvl  = h_take ? hs[1] : h_acc;
  assign v_lvl  = v_take ? vs[1] : v_acc;
  assign h_rise = h_take & hs[1];
  assign v_rise = v_take & vs[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_acc <= 1'b0;
      v_acc <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_acc <= h_lvl;
      v_acc <= v_lvl;
      h_cnt <= (hs[1] == h_acc || h_take) ? 2'd0 : h_cnt + 2'd1;
      v_cnt <= (vs[1] == v_acc || v_take) ? 2'd0 : v_cnt + 2'd1;
    end
  end
`else
  assign h_lvl  = hs[1];
  assign v_lvl  = vs[1];
  assign h_rise = hs[1] & ~hs[2];
  assign v_rise = vs[1] & ~vs[2];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_hsync      <= 1'b0;
      o_vsync      <= 1'b0;
      o_hsync_rise <= 1'b0;
      o_vsync_rise <= 1'b0;
    end else begin
      o_hsync      <= h_lvl;
      o_vsync      <= v_lvl;
      o_hsync_rise <= h_rise;
      o_vsync_rise <= v_rise;
    end
  end

  // Frame counters and the latched measurement handed to the classifier one clock later.
  logic [10:0] line_cnt, m_lines;
  logic [23:0] frm_cnt, m_period;
  logic        m_vld, timeout;

  assign timeout = frm_cnt >= TO_CLKS;

  always_ff @(posedge clk) begin
    if (!reset) begin
      line_cnt <= '0;
      frm_cnt  <= '0;
      m_lines  <= '0;
      m_period <= '0;
      m_vld    <= 1'b0;
    end else begin
      m_vld <= v_rise;
      if (v_rise) begin
        m_lines  <= line_cnt;
        m_period <= (&frm_cnt) ? frm_cnt : frm_cnt + 24'd1;
        frm_cnt  <= '0;
        line_cnt <= h_rise ? 11'd1 : 11'd0;
      end else begin
        if (!(&frm_cnt)) frm_cnt <= frm_cnt + 24'd1;
        if (h_rise && !(&line_cnt)) line_cnt <= line_cnt + 11'd1;
      end
    end
  end

  state_t      state, state_n;
  logic [3:0]  stab, stab_n;
  logic [1:0]  cand, cand_q, cand_n;
  logic [10:0] lines_n;
  logic [23:0] clks_n;
  logic        valid_n, f50_n, f60_n, pass_n;

  assign cand = {m_period >= P50_MIN, m_lines > PASS_L};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      stab          <= '0;
      cand_q        <= '0;
      o_lines       <= '0;
      o_frame_clks  <= '0;
      o_valid       <= 1'b0;
      o_50hz        <= 1'b0;
      o_60hz        <= 1'b0;
      o_passthrough <= 1'b0;
    end else begin
      state         <= state_n;
      stab          <= stab_n;
      cand_q        <= cand_n;
      o_lines       <= lines_n;
      o_frame_clks  <= clks_n;
      o_valid       <= valid_n;
      o_50hz        <= f50_n;
      o_60hz        <= f60_n;
      o_passthrough <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    stab_n  = stab;
    cand_n  = cand_q;
    lines_n = o_lines;
    clks_n  = o_frame_clks;
    valid_n = o_valid;
    f50_n   = o_50hz;
    f60_n   = o_60hz;
    pass_n  = o_passthrough;
    if (timeout) begin
      state_n = IDLE;
      stab_n  = '0;
      valid_n = 1'b0;
      f50_n   = 1'b0;
      f60_n   = 1'b0;
      pass_n  = 1'b0;
    end else if (m_vld) begin
      case (state)
        IDLE: state_n = MEASURE;
        default: begin
          lines_n = m_lines;
          clks_n  = m_period;
          cand_n  = cand;
          // stab == 0 means no previous candidate since arming
          if (stab != 4'd0 && cand == cand_q)
            stab_n = (stab >= STAB) ? STAB : stab + 4'd1;
          else
            stab_n = 4'd1;
          if (stab_n == STAB) begin
            state_n = LOCKED;
            valid_n = 1'b1;
            f50_n   = cand[1];
            f60_n   = ~cand[1];
            pass_n  = cand[0];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pal_mode_detect.sv
// Randomized frame stimulus for pal_mode_detect checked against a history-based class model.
module tb_pal_mode_detect;
  localparam int CLK_HZ  = 200_000;
  localparam int TIMEOUT = CLK_HZ / 20;
  localparam int P50     = CLK_HZ / 55;
  localparam int NSTAB   = 3;
`ifdef PAL_MODE_DETECT_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif

  logic        clk = 1'b0, reset = 1'b0, i_pal_hsync = 1'b0, i_pal_vsync = 1'b0;
  logic        o_hsync, o_vsync, o_hsync_rise, o_vsync_rise;
  logic [10:0] o_lines;
  logic [23:0] o_frame_clks;
  logic        o_valid, o_50hz, o_60hz, o_passthrough;

  pal_mode_detect #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .i_pal_hsync(i_pal_hsync), .i_pal_vsync(i_pal_vsync),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_hsync_rise(o_hsync_rise), .o_vsync_rise(o_vsync_rise),
    .o_lines(o_lines), .o_frame_clks(o_frame_clks), .o_valid(o_valid),
    .o_50hz(o_50hz), .o_60hz(o_60hz), .o_passthrough(o_passthrough));

  always #5 clk = ~clk;

  int ntot = 0, npass = 0, nfail = 0, fidx = 0, lastp = 0;
  // Model: candidate history since arming; locked class = last NSTAB candidates all equal.
  int armed = 0, exp_valid = 0, exp_c = 0, exp_lines = 0, exp_clks = 0;
  int prev_lines = 0, prev_period = 0;
  int hist[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    assert (act === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_rise();
    if (armed == 0) armed = 1;
    else begin
      int c;
      int same;
      c = ((prev_period >= P50) ? 2 : 0) + ((prev_lines > 400) ? 1 : 0);
      exp_lines = prev_lines;
      exp_clks  = prev_period;
      hist.push_back(c);
      same = (hist.size() >= NSTAB) ? 1 : 0;
      for (int k = 1; k <= NSTAB && k <= hist.size(); k++)
        if (hist[hist.size() - k] != c) same = 0;
      if (same != 0) begin
        exp_valid = 1;
        exp_c     = c;
      end
    end
  endtask

  task automatic model_clear();
    armed = 0;
    hist.delete();
    exp_valid = 0;
  endtask

  task automatic check_flags(input string tag);
    chk($sformatf("%s_valid", tag), 32'(o_valid), 32'(exp_valid));
    chk($sformatf("%s_50hz", tag), 32'(o_50hz), 32'(exp_valid != 0 && exp_c >= 2));
    chk($sformatf("%s_60hz", tag), 32'(o_60hz), 32'(exp_valid != 0 && exp_c < 2));
    chk($sformatf("%s_pass", tag), 32'(o_passthrough), 32'(exp_valid != 0 && (exp_c % 2) == 1));
    chk($sformatf("%s_lines", tag), 32'(o_lines), 32'(exp_lines));
    chk($sformatf("%s_clks", tag), 32'(o_frame_clks), 32'(exp_clks));
  endtask

  // One frame: vsync rise at c=0, nl hsync pulses of width hw every lc clocks from c=20,
  // nsp of them followed by a 2-clock spike.
  task automatic frame(input int nl, input int lc, input int per, input int hw, input int nsp);
    int vr, hr, off, ln, ph;
    vr = 0;
    hr = 0;
    fidx++;
    model_rise();
    for (int c = 0; c < per; c++) begin
      @(negedge clk);
      vr += int'(o_vsync_rise);
      hr += int'(o_hsync_rise);
      if (c == 16) check_flags($sformatf("f%0d", fidx));
      i_pal_vsync = (c < 4);
      off = c - 20;
      ln  = off / lc;
      ph  = off % lc;
      i_pal_hsync = (off >= 0 && ln < nl) && (ph < hw || (ln < nsp && (ph == hw + 2 || ph == hw + 3)));
    end
    prev_lines  = nl + ((FILT != 0) ? 0 : nsp);
    prev_period = per;
    lastp       = per;
    chk($sformatf("f%0d_vrise_cnt", fidx), 32'(vr), 32'd1);
    chk($sformatf("f%0d_hrise_cnt", fidx), 32'(hr), 32'(prev_lines));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_pal_hsync = 1'b0;
      i_pal_vsync = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk($sformatf("%s_hsync", tag), 32'(o_hsync), 32'd0);
    chk($sformatf("%s_vsync", tag), 32'(o_vsync), 32'd0);
    chk($sformatf("%s_hrise", tag), 32'(o_hsync_rise), 32'd0);
    chk($sformatf("%s_vrise", tag), 32'(o_vsync_rise), 32'd0);
    check_flags(tag);
  endtask

  initial begin
    reset = 1'b0;
    idle(3);
    check_all_zero("reset");
    reset = 1'b1;
    // 50 Hz: 312 lines; locks on the 4th vsync rise
    for (int i = 0; i < 4; i++) frame(312, 12, 4000 + $urandom_range(0, 200), 3 + $urandom_range(0, 3), 0);
    // 60 Hz: 262 lines; class flips on the 3rd new measurement, valid held meanwhile
    for (int i = 0; i < 3; i++) frame(262, 6, 3333 - $urandom_range(0, 100), 3, 0);
    // VGA 525 lines at 60 Hz
    for (int i = 0; i < 4; i++) frame(525, 6, 3333 - $urandom_range(0, 100), 3, 0);
    // vsync stops: still valid just before the timeout, cleared just after
    idle(TIMEOUT - lastp - 10);
    chk("pre_timeout_valid", 32'(o_valid), 32'(exp_valid));
    idle(30);
    model_clear();
    check_flags("timeout");
    // restart with hsync spikes; relock after 4 rises
    for (int i = 0; i < 4; i++) frame(312, 12, 4000 + $urandom_range(0, 200), 3, 5);
    chk("pre_reset_valid", 32'(o_valid), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_clear();
    exp_lines = 0;
    exp_clks  = 0;
    check_all_zero("midreset");
    reset = 1'b1;
    frame(312, 12, 4000, 3, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
